// File: rtl/midi_msg_parser.sv
// midi_msg_parser: assembles MIDI messages from received bytes with running status, real-time interleave and SysEx skipping
module midi_msg_parser #(
  parameter bit         OMNI    = 1'b1,
  parameter logic [3:0] CHANNEL = 4'd0
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       byte_ready,
  input  logic [7:0] midi_byte_in,
  output logic       msg_valid,
  output logic [7:0] msg_status,
  output logic [6:0] msg_data1,
  output logic [6:0] msg_data2,
  output logic [1:0] msg_len,
  output logic       rt_valid,
  output logic [7:0] rt_byte,
  output logic [7:0] err_count
);
  localparam logic [1:0] WAIT_STATUS = 2'd0, WAIT_D1 = 2'd1, WAIT_D2 = 2'd2, SYSEX = 2'd3;
  logic [1:0] state, state_n;
  logic [7:0] run_status, run_n, cur_status, cur_n, e_status;
  logic [6:0] d1_hold, d1_n, e_d1, e_d2;
  logic [1:0] e_len, err_inc;
  logic       byte_ready_q, len2, len2_n, emit, rt, pass, accept;
  logic [8:0] err_sum;
  logic [7:0] b;
  assign b      = midi_byte_in;
  assign accept = byte_ready & ~byte_ready_q;
  // Cx/Dx carry one data byte; everything else in 80-EF carries two
  always_comb begin
    state_n  = state;
    run_n    = run_status;
    cur_n    = cur_status;
    d1_n     = d1_hold;
    len2_n   = len2;
    err_inc  = '0;
    emit     = 1'b0;
    e_status = cur_status;
    e_d1     = '0;
    e_d2     = '0;
    e_len    = '0;
    rt       = 1'b0;
    if (accept) begin
      if (&b[7:3]) rt = 1'b1;
      else if (b[7]) begin
        if (state == WAIT_D1 || state == WAIT_D2) err_inc = 2'd1;
        if (b < 8'hF0) begin
          cur_n   = b;
          run_n   = b;
          state_n = WAIT_D1;
          len2_n  = b[7:5] != 3'b110;
        end else begin
          run_n   = '0;
          state_n = WAIT_STATUS;
          if (b == 8'hF1 || b == 8'hF2 || b == 8'hF3) begin
            cur_n   = b;
            state_n = WAIT_D1;
            len2_n  = b == 8'hF2;
          end else if (b == 8'hF6) begin
            emit     = 1'b1;
            e_status = b;
          end else if (b == 8'hF0) state_n = SYSEX;
          else if (!(b == 8'hF7 && state == SYSEX)) err_inc = err_inc + 2'd1;
        end
      end else if (state == WAIT_STATUS) begin
        if (run_status != 8'h00) begin
          cur_n    = run_status;
          e_status = run_status;
          if (run_status[7:5] == 3'b110) begin
            emit  = 1'b1;
            e_d1  = b[6:0];
            e_len = 2'd1;
          end else begin
            d1_n    = b[6:0];
            len2_n  = 1'b1;
            state_n = WAIT_D2;
          end
        end else err_inc = 2'd1;
      end else if (state == WAIT_D1) begin
        if (len2) begin
          d1_n    = b[6:0];
          state_n = WAIT_D2;
        end else begin
          emit    = 1'b1;
          e_d1    = b[6:0];
          e_len   = 2'd1;
          state_n = WAIT_STATUS;
        end
      end else if (state == WAIT_D2) begin
        emit    = 1'b1;
        e_d1    = d1_hold;
        e_d2    = b[6:0];
        e_len   = 2'd2;
        state_n = WAIT_STATUS;
      end
    end
    pass    = OMNI || e_status[7:4] == 4'hF || e_status[3:0] == CHANNEL;
    err_sum = {1'b0, err_count} + {7'b0, err_inc};
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      byte_ready_q <= 1'b1;
      state        <= WAIT_STATUS;
      run_status   <= '0;
      cur_status   <= '0;
      d1_hold      <= '0;
      len2         <= 1'b0;
      msg_valid    <= 1'b0;
      msg_status   <= '0;
      msg_data1    <= '0;
      msg_data2    <= '0;
      msg_len      <= '0;
      rt_valid     <= 1'b0;
      rt_byte      <= '0;
      err_count    <= '0;
    end else begin
      byte_ready_q <= byte_ready;
      state        <= state_n;
      run_status   <= run_n;
      cur_status   <= cur_n;
      d1_hold      <= d1_n;
      len2         <= len2_n;
      msg_valid    <= emit & pass;
      rt_valid     <= rt;
      err_count    <= err_sum[8] ? 8'hFF : err_sum[7:0];
      if (emit & pass) begin
        msg_status <= e_status;
        msg_data1  <= e_d1;
        msg_data2  <= e_d2;
        msg_len    <= e_len;
      end
      if (rt) rt_byte <= b;
    end
  end
endmodule

// File: tb/tb_midi_msg_parser.sv
// tb_midi_msg_parser: directed scoreboard bench for an omni instance and a channel-5 filtered instance
module tb_midi_msg_parser;
  logic       clk = 1'b0, rst = 1'b1, byte_ready = 1'b0;
  logic [7:0] midi_byte = 8'h00;
  logic       a_mv, a_rv, f_mv, f_rv;
  logic [7:0] a_st, a_rb, a_err, f_st, f_rb, f_err;
  logic [6:0] a_d1, a_d2, f_d1, f_d2;
  logic [1:0] a_len, f_len;
  logic [23:0] qa[$], qf[$];
  logic [7:0]  ra[$], rf[$];
  logic [23:0] exp_m;
  logic [7:0]  exp_r;
  int vectors = 0, miscompares = 0;

  always #10 clk = ~clk;

  midi_msg_parser #(.OMNI(1'b1), .CHANNEL(4'd0)) dut_a (
    .clk(clk), .rst(rst), .byte_ready(byte_ready), .midi_byte_in(midi_byte),
    .msg_valid(a_mv), .msg_status(a_st), .msg_data1(a_d1), .msg_data2(a_d2), .msg_len(a_len),
    .rt_valid(a_rv), .rt_byte(a_rb), .err_count(a_err));
  midi_msg_parser #(.OMNI(1'b0), .CHANNEL(4'd5)) dut_f (
    .clk(clk), .rst(rst), .byte_ready(byte_ready), .midi_byte_in(midi_byte),
    .msg_valid(f_mv), .msg_status(f_st), .msg_data1(f_d1), .msg_data2(f_d2), .msg_len(f_len),
    .rt_valid(f_rv), .rt_byte(f_rb), .err_count(f_err));

  function automatic logic [23:0] m(input logic [7:0] s, input logic [6:0] d1, input logic [6:0] d2, input logic [1:0] l);
    return {s, d1, d2, l};
  endfunction

  always @(negedge clk) begin
    if (a_mv) begin
      vectors++;
      exp_m = qa.size() != 0 ? qa.pop_front() : 24'hxxxxxx;
      assert ({a_st, a_d1, a_d2, a_len} === exp_m) else begin
        miscompares++;
        $error("FAIL omni_msg got %h exp %h", {a_st, a_d1, a_d2, a_len}, exp_m);
      end
    end
    if (f_mv) begin
      vectors++;
      exp_m = qf.size() != 0 ? qf.pop_front() : 24'hxxxxxx;
      assert ({f_st, f_d1, f_d2, f_len} === exp_m) else begin
        miscompares++;
        $error("FAIL filt_msg got %h exp %h", {f_st, f_d1, f_d2, f_len}, exp_m);
      end
    end
    if (a_rv) begin
      vectors++;
      exp_r = ra.size() != 0 ? ra.pop_front() : 8'hxx;
      assert (a_rb === exp_r) else begin
        miscompares++;
        $error("FAIL omni_rt got %h exp %h", a_rb, exp_r);
      end
    end
    if (f_rv) begin
      vectors++;
      exp_r = rf.size() != 0 ? rf.pop_front() : 8'hxx;
      assert (f_rb === exp_r) else begin
        miscompares++;
        $error("FAIL filt_rt got %h exp %h", f_rb, exp_r);
      end
    end
  end

  task automatic send(input logic [7:0] b, input int hold = 1);
    @(posedge clk); #1;
    midi_byte = b;
    byte_ready = 1'b1;
    repeat (hold) @(posedge clk);
    #1 byte_ready = 1'b0;
    repeat (2) @(posedge clk);
  endtask

  task automatic push(input logic [23:0] v, input bit to_f);
    qa.push_back(v);
    if (to_f) qf.push_back(v);
  endtask

  task automatic push_rt(input logic [7:0] v);
    ra.push_back(v);
    rf.push_back(v);
  endtask

  task automatic idle_err(input string tag, input logic [7:0] e);
    @(negedge clk);
    vectors++;
    assert (qa.size() + qf.size() + ra.size() + rf.size() == 0) else begin
      miscompares++;
      $error("FAIL %s_pending got %0d exp 0", tag, qa.size() + qf.size() + ra.size() + rf.size());
    end
    vectors++;
    assert ({a_err, f_err} === {e, e}) else begin
      miscompares++;
      $error("FAIL %s_err got %h/%h exp %h", tag, a_err, f_err, e);
    end
  endtask

  task automatic chk_reset(input string tag);
    @(negedge clk);
    vectors++;
    assert ({a_mv, a_st, a_d1, a_d2, a_len, a_rv, a_rb, a_err, f_mv, f_st, f_d1, f_d2, f_len, f_rv, f_rb, f_err} === '0) else begin
      miscompares++;
      $error("FAIL %s got a=%h/%h/%h/%h/%h f=%h/%h/%h exp 0", tag, a_st, a_d1, a_d2, a_len, a_err, f_st, f_len, f_err);
    end
  endtask

  initial begin
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    chk_reset("reset");
    push(m(8'h90, 7'h3C, 7'h64, 2'd2), 0);
    send(8'h90); send(8'h3C); send(8'h64);
    idle_err("note_on", 8'd0);
    push(m(8'h90, 7'h3E, 7'h00, 2'd2), 0);
    send(8'h3E); send(8'h00);
    push(m(8'hC2, 7'h07, 7'h00, 2'd1), 0);
    send(8'hC2); send(8'h07);
    idle_err("running", 8'd0);
    push_rt(8'hF8);
    push(m(8'h90, 7'h3C, 7'h64, 2'd2), 0);
    send(8'h90); send(8'h3C); send(8'hF8); send(8'h64);
    push_rt(8'hFA);
    send(8'hFA);
    idle_err("rt_mix", 8'd0);
    send(8'hF0); send(8'h01); send(8'h02); send(8'hF7); send(8'h3C);
    idle_err("sysex", 8'd1);
    send(8'h90); send(8'h3C); send(8'hB0);
    push(m(8'hB0, 7'h07, 7'h7F, 2'd2), 0);
    send(8'h07); send(8'h7F);
    idle_err("partial", 8'd2);
    push(m(8'hC5, 7'h07, 7'h00, 2'd1), 1);
    send(8'hC5); send(8'h07);
    push(m(8'hC4, 7'h07, 7'h00, 2'd1), 0);
    send(8'hC4); send(8'h07);
    push(m(8'hC4, 7'h09, 7'h00, 2'd1), 0);
    send(8'h09);
    idle_err("filter", 8'd2);
    push(m(8'hF6, 7'h00, 7'h00, 2'd0), 1);
    send(8'hF6);
    send(8'hF4);
    idle_err("f6_f4", 8'd3);
    send(8'h90);
    push(m(8'hF1, 7'h05, 7'h00, 2'd1), 1);
    send(8'hF1); send(8'h05);
    send(8'hF5); send(8'h7F);
    idle_err("syscommon", 8'd6);
    push(m(8'h93, 7'h3C, 7'h40, 2'd2), 0);
    send(8'hF0); send(8'h01); send(8'h93); send(8'h3C); send(8'h40);
    idle_err("sysex_term", 8'd6);
    push_rt(8'hFE);
    send(8'hFE, 10);
    idle_err("held_high", 8'd6);
    send(8'hF7);
    for (int i = 0; i < 248; i++) send(8'h00);
    idle_err("err_full", 8'd255);
    for (int i = 0; i < 5; i++) send(8'h00);
    idle_err("err_sat", 8'd255);
    send(8'h90); send(8'h3C);
    @(posedge clk); #1;
    midi_byte = 8'h64;
    byte_ready = 1'b1;
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    repeat (6) @(posedge clk);
    chk_reset("reset_mid");
    #1 byte_ready = 1'b0;
    repeat (2) @(posedge clk);
    push(m(8'h90, 7'h3C, 7'h64, 2'd2), 0);
    send(8'h90); send(8'h3C); send(8'h64);
    idle_err("post_reset", 8'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule

// File: doc/midi_msg_parser.md
# midi_msg_parser

Consumes the byte stream from the MIDI UART byte receiver and assembles complete MIDI messages: channel voice, system common, and real-time. Handles running status, interleaved real-time bytes, and SysEx skipping. Emits one pulse per complete message for the synth/voice-allocation logic. It sits directly downstream of the byte receiver and is the only consumer of its byte_ready/byte outputs.

## Interface

Parameters:
- OMNI, 1: 1 = pass channel voice messages on all channels; 0 = pass only CHANNEL.
- CHANNEL, 0: 4-bit channel number used when OMNI=0.

Ports:
- clk  in  1  50 MHz system clock.
- rst  in  1  synchronous, active-high reset.
- byte_ready  in  1  level from byte receiver; a 0->1 transition marks a new byte.
- midi_byte_in  in  8  received byte; valid whenever byte_ready is high.
- msg_valid  out  1  one-cycle pulse; msg_* fields valid in the same cycle.
- msg_status  out  8  status byte of the message (running status resolved).
- msg_data1  out  7  first data byte (0 if none).
- msg_data2  out  7  second data byte (0 if none).
- msg_len  out  2  number of data bytes: 0, 1 or 2.
- rt_valid  out  1  one-cycle pulse for a real-time byte.
- rt_byte  out  8  real-time byte (F8-FF).
- err_count  out  8  saturating count of protocol errors.

## Operation

- Accept strobe: accept = byte_ready & ~byte_ready_q. byte_ready_q resets to 1, so a byte_ready already high at reset release is ignored.
- States: WAIT_STATUS, WAIT_D1, WAIT_D2, SYSEX. Registers: run_status (8b, 0 = none), d1_hold (7b), cur_status (8b).
- Real-time byte (F8-FF) in any state:
  - rt_valid=1, rt_byte=byte.
  - State, run_status, cur_status and d1_hold are unchanged.
- Status 80-EF:
  - cur_status = run_status = byte.
  - Go to WAIT_D1.
  - Expected data length is 1 for Cx/Dx and 2 otherwise.
- System common status (clears run_status to 0 in every case):
  - F1 or F3: cur_status=byte, go to WAIT_D1, length 1.
  - F2: cur_status=byte, go to WAIT_D1, length 2.
  - F6: emit immediately with msg_len=0; stay in WAIT_STATUS.
  - F0: go to SYSEX.
  - F4, F5: discard, err_count+1, go to WAIT_STATUS.
  - F7 outside SYSEX: discard, err_count+1.
- SYSEX:
  - Data bytes are discarded.
  - F7: go to WAIT_STATUS with no output.
  - Any other non-real-time status: terminates the SysEx and is processed as a new status byte. No error is counted.
- Data byte (bit7=0):
  - WAIT_STATUS with run_status!=0: cur_status=run_status. The byte is the first data byte (emit if length 1, otherwise d1_hold=byte and go to WAIT_D2).
  - WAIT_STATUS with run_status=0: discard, err_count+1.
  - WAIT_D1: if length 1, emit (data1=byte, data2=0, len=1) and go to WAIT_STATUS. If length 2, d1_hold=byte and go to WAIT_D2.
  - WAIT_D2: emit (data1=d1_hold, data2=byte, len=2) and go to WAIT_STATUS.
- Non-real-time status arriving in WAIT_D1 or WAIT_D2: partial message dropped, err_count+1, then the new status is processed normally in the same cycle.
- Channel filter:
  - With OMNI=0, a channel voice message whose status[3:0]!=CHANNEL is fully parsed and updates run_status.
  - Its msg_valid is suppressed.
  - System messages are never filtered.
- err_count saturates at 255 and never wraps.

## Timing

- All outputs are registered.
- If accept is true during cycle N, the resulting msg_valid/rt_valid is high in cycle N+1 for exactly one cycle.
- msg_* and rt_byte hold their last values between pulses.
- At most one accept per cycle. msg_valid and rt_valid are never high in the same cycle, because one byte produces at most one output.
- Reset values:
  - msg_valid=0, rt_valid=0.
  - msg_status=0, msg_data1=0, msg_data2=0, msg_len=0.
  - rt_byte=0, err_count=0.
  - run_status=0, state=WAIT_STATUS, byte_ready_q=1.
- Reset mid-message: the partial message is discarded and no pulse is produced. The first byte is accepted only after byte_ready has been seen low at least once post-reset.
- byte_ready held high for many cycles yields exactly one accept. Successive bytes require a low period of at least one cycle.

## Test plan

- Bytes 90 3C 64 -> one msg_valid with status=90, data1=3C, data2=64, len=2; err_count=0.
- Running status: 90 3C 64 3E 00 -> two pulses (90/3C/64, then 90/3E/00). Then C2 07 -> status=C2, data1=07, len=1.
- Real-time interleave: 90 3C F8 64 -> rt_valid with rt_byte=F8 first, then one msg 90/3C/64. Also FA alone -> rt pulse only, no msg_valid.
- SysEx and errors:
  - F0 01 02 F7 3C -> no msg_valid; err_count=1 (stray 3C, run_status cleared).
  - Then 90 3C B0 -> err_count=2, and B0 starts a new message.
- Filter: OMNI=0, CHANNEL=5.
  - C5 07 -> msg_valid with C5/07.
  - C4 07 -> no pulse. A following 09 also produces no pulse, because running status is C4.
- Reset:
  - Assert rst after 90 3C, with byte_ready held high through reset release -> no pulse and no accept until byte_ready toggles.
  - Then 90 3C 64 -> normal message.
